fibonacci_checker: RTL

Consumes a stream of Fibonacci samples, such as those from the team's 8-bit Fibonacci generator, and checks each one against an internally regenerated reference sequence. The sequence is 0,1,1,2,3,5,8,13,21,34,55,89 and then repeats from 0. The checker locks on a 0 sample, flags every mismatch, counts errors and completed periods, and re-hunts after loss of lock. It sits on the receive side of the generator's output bus, and is used as a self-test monitor in FPGA designs and testbenches.

---
 rtl/fibonacci_checker.sv | 112 +++++++++++
 1 files changed

// File: rtl/fibonacci_checker.sv
// Checks a sample stream against a regenerated Fibonacci sequence.
// Locks on a 0, flags mismatches, counts errors and completed periods.
module fibonacci_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LAST_INDEX = 11
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic             i_Valid,
  input  logic [WIDTH-1:0] i_Value,
  output logic             o_Locked,
  output logic             o_Error,
  output logic [4:0]       o_Index,
  output logic [7:0]       o_ErrorCount,
  output logic [7:0]       o_Wraps
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  localparam logic [4:0] LastIdx = 5'(LAST_INDEX);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       index_q, index_d;
  logic             error_q, error_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       wraps_q, wraps_d;
  logic [WIDTH-1:0] expected;
  logic             at_last;

  assign at_last  = (index_q == LastIdx);
  // After the final term the next period starts again at 0.
  assign expected = at_last ? '0 : b_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    index_d   = index_q;
    error_d   = 1'b0;
    err_cnt_d = err_cnt_q;
    wraps_d   = wraps_q;
    if (i_Valid) begin
      unique case (state_q)
        StHunt: begin
          if (i_Value == '0) begin
            state_d = StLocked;
            index_d = '0;
            a_d     = '0;
            b_d     = WIDTH'(1);
          end
        end
        StLocked: begin
          if (i_Value == expected) begin
            if (at_last) begin
              index_d = '0;
              a_d     = '0;
              b_d     = WIDTH'(1);
              wraps_d = wraps_q + 8'd1;
            end else begin
              index_d = index_q + 5'd1;
              a_d     = b_q;
              b_d     = a_q + b_q;
            end
          end else begin
            error_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
            // A mismatching 0 is also a valid resync point.
            if (i_Value == '0) begin
              index_d = '0;
              a_d     = '0;
              b_d     = WIDTH'(1);
            end else begin
              state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= StHunt;
      a_q       <= '0;
      b_q       <= WIDTH'(1);
      index_q   <= '0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      wraps_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      index_q   <= index_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      wraps_q   <= wraps_d;
    end
  end

  assign o_Locked     = (state_q == StLocked);
  assign o_Error      = error_q;
  assign o_Index      = index_q;
  assign o_ErrorCount = err_cnt_q;
  assign o_Wraps      = wraps_q;

endmodule
